// File: rtl/pcpu_mem.sv
`default_nettype none
// pcpu_mem: instruction and data memories for a small CPU, filled by a loader.
// A LOAD -> RUN -> HALTED sequencer decides whether the loader or the CPU owns the memories.
module pcpu_mem #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 16,
  parameter logic [4:0]  HALT_OP = 5'b00001
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] i_datain,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [DW-1:0] d_dataout,
  output logic [DW-1:0] d_datain,
  output logic          cpu_enable,
  output logic          halted,
  input  logic          ld_valid,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          ld_done,
  input  logic          ld_start,
  output logic [AW:0]   ld_count,
  output logic          cpu_wr_err
);
  localparam logic [1:0]  S_LOAD    = 2'd0;
  localparam logic [1:0]  S_RUN     = 2'd1;
  localparam logic [1:0]  S_HALTED  = 2'd2;
  localparam int unsigned DEPTH     = 1 << AW;
  localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_imem [DEPTH];
  logic [DW-1:0] r_dmem [DEPTH];

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_ld_ready;
  logic [AW:0]   r_ld_count;
  logic          r_cpu_wr_err;
  logic [DW-1:0] r_i_data;
  logic [DW-1:0] r_d_data;

  logic          w_run;
  logic          w_xfer;
  logic          w_halt_seen;
  logic          w_cpu_wr;
  logic          w_restart;
  logic [DW-1:0] w_d_rd;
  logic          w_dm_we;
  logic [AW-1:0] w_dm_addr;
  logic [DW-1:0] w_dm_wdata;

  assign w_run       = (r_state == S_RUN);
  // r_ld_ready is only ever set while in LOAD, so loader and CPU writes never collide.
  assign w_xfer      = ld_valid & r_ld_ready;
  assign w_halt_seen = (r_i_data[DW-1:DW-5] == HALT_OP);
  assign w_cpu_wr    = w_run & d_we;
  assign w_restart   = ld_start & (r_state != S_LOAD);
  assign w_d_rd      = w_cpu_wr ? d_dataout : r_dmem[d_addr];

  assign w_dm_we    = (w_xfer & ld_sel) | w_cpu_wr;
  assign w_dm_addr  = w_xfer ? ld_addr : d_addr;
  assign w_dm_wdata = w_xfer ? ld_data : d_dataout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:   if (ld_done) w_state_nxt = S_RUN;
      S_RUN: begin
        if (ld_start)         w_state_nxt = S_LOAD;
        else if (w_halt_seen) w_state_nxt = S_HALTED;
      end
      S_HALTED: if (ld_start) w_state_nxt = S_LOAD;
      default:  w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_xfer && !ld_sel) r_imem[ld_addr] <= ld_data;
    if (w_dm_we)           r_dmem[w_dm_addr] <= w_dm_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_LOAD;
      r_ld_ready   <= 1'b0;
      r_ld_count   <= '0;
      r_cpu_wr_err <= 1'b0;
      r_i_data     <= '0;
      r_d_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_ready <= (w_state_nxt == S_LOAD);
      if (w_restart)
        r_ld_count <= '0;
      else if (w_xfer && (r_ld_count != COUNT_MAX))
        r_ld_count <= r_ld_count + 1'b1;
      if (d_we && !w_run)
        r_cpu_wr_err <= 1'b1;
      // The instruction register freezes on the halting edge so it keeps showing the HALT word.
      if (w_state_nxt == S_LOAD) begin
        r_i_data <= '0;
        r_d_data <= '0;
      end else if (w_run) begin
        r_d_data <= w_d_rd;
        if (w_state_nxt == S_RUN) r_i_data <= r_imem[pc];
      end
    end
  end

  assign i_datain   = r_i_data;
  assign d_datain   = r_d_data;
  assign cpu_enable = w_run;
  assign halted     = (r_state == S_HALTED);
  assign ld_ready   = r_ld_ready;
  assign ld_count   = r_ld_count;
  assign cpu_wr_err = r_cpu_wr_err;
endmodule
`default_nettype wire

// File: tb/tb_pcpu_mem.sv
`default_nettype none
// Bench for pcpu_mem: directed load/run/halt/reset scenarios plus random traffic,
// checked by a scoreboard fed from a behavioural model of the memories and sequencer.
module tb_pcpu_mem;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc, d_addr, ld_addr;
  logic [15:0] i_datain, d_datain, d_dataout, ld_data;
  logic        d_we, cpu_enable, halted, ld_valid, ld_sel, ld_ready, ld_done, ld_start, cpu_wr_err;
  logic [8:0]  ld_count;

  always #5 clk = ~clk;

  pcpu_mem #(.AW(8), .DW(16), .HALT_OP(5'b00001)) dut (
    .clk(clk), .reset(reset), .pc(pc), .i_datain(i_datain),
    .d_addr(d_addr), .d_we(d_we), .d_dataout(d_dataout), .d_datain(d_datain),
    .cpu_enable(cpu_enable), .halted(halted),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_start(ld_start),
    .ld_count(ld_count), .cpu_wr_err(cpu_wr_err)
  );

  typedef enum logic [1:0] {M_LOAD, M_RUN, M_HALT} mode_t;
  typedef struct packed {
    logic [31:0] step;
    logic [15:0] idata;
    logic [15:0] ddata;
    logic        en;
    logic        hlt;
    logic        rdy;
    logic        err;
    logic [8:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          step_no = 0;

  mode_t       m_mode;
  bit          m_rdy, m_err;
  int          m_cnt;
  logic [15:0] m_i, m_d;
  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];

  task automatic push_exp();
    exp_t e;
    e.step  = step_no;
    e.idata = m_i;
    e.ddata = m_d;
    e.en    = (m_mode == M_RUN);
    e.hlt   = (m_mode == M_HALT);
    e.rdy   = m_rdy;
    e.err   = m_err;
    e.cnt   = 9'(m_cnt);
    sb.push_back(e);
    step_no++;
  endtask

  task automatic model_reset();
    m_mode = M_LOAD; m_rdy = 0; m_err = 0; m_cnt = 0; m_i = 16'h0; m_d = 16'h0;
  endtask

  // Effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    mode_t nm;
    bit    xfer;
    if (!reset) begin
      model_reset();
    end else begin
      nm   = m_mode;
      xfer = ld_valid && m_rdy;
      if (d_we && m_mode != M_RUN) m_err = 1;
      case (m_mode)
        M_LOAD: begin
          if (xfer) begin
            if (ld_sel) m_dmem[ld_addr] = ld_data;
            else        m_imem[ld_addr] = ld_data;
            if (m_cnt < 256) m_cnt++;
          end
          if (ld_done) nm = M_RUN;
        end
        M_RUN: begin
          if (d_we) m_dmem[d_addr] = d_dataout;
          if (ld_start) nm = M_LOAD;
          else begin
            m_d = m_dmem[d_addr];
            if (m_i[15:11] == 5'b00001) nm = M_HALT;
            else m_i = m_imem[pc];
          end
        end
        default: if (ld_start) nm = M_LOAD;
      endcase
      if (nm == M_LOAD && m_mode != M_LOAD) begin
        m_cnt = 0; m_i = 16'h0; m_d = 16'h0;
      end
      m_mode = nm;
      m_rdy  = (nm == M_LOAD);
    end
  endtask

  task automatic tick();
    model_edge();
    push_exp();
    @(negedge clk);
  endtask

  task automatic clear_in();
    pc = 0; d_addr = 0; d_we = 0; d_dataout = 0;
    ld_valid = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; ld_done = 0; ld_start = 0;
  endtask

  task automatic load1(input bit sel, input logic [7:0] a, input logic [15:0] d);
    ld_valid = 1; ld_sel = sel; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 0;
  endtask

  task automatic chk(input string nm, input int st, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL step%0d %s got=%h exp=%h", st, nm, got, want);
    end
  endtask

  // Monitor: after every clock edge or asynchronous reset, compare the DUT against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("i_datain",   e.step, i_datain, e.idata);
        chk("d_datain",   e.step, d_datain, e.ddata);
        chk("cpu_enable", e.step, {15'h0, cpu_enable}, {15'h0, e.en});
        chk("halted",     e.step, {15'h0, halted},     {15'h0, e.hlt});
        chk("ld_ready",   e.step, {15'h0, ld_ready},   {15'h0, e.rdy});
        chk("cpu_wr_err", e.step, {15'h0, cpu_wr_err}, {15'h0, e.err});
        chk("ld_count",   e.step, {7'h0, ld_count},    {7'h0, e.cnt});
      end
    end
  end

  initial begin
    clear_in();
    reset = 0;
    model_reset();
    @(negedge clk);
    tick(); tick();
    reset = 1;
    tick();

    // Fill both memories completely; the count saturates at 256.
    for (int i = 0; i < 512; i++) load1(i >= 256, 8'(i), 16'($urandom));
    ld_done = 1; tick(); ld_done = 0;
    ld_start = 1; tick(); ld_start = 0;

    load1(0, 8'h00, 16'h1101);
    load1(0, 8'h01, 16'h0800);
    load1(1, 8'h01, 16'h00C3);
    ld_done = 1; tick(); ld_done = 0;
    pc = 8'h00; tick();
    d_addr = 8'h01; tick();
    d_we = 1; d_dataout = 16'hFC00; tick();
    d_we = 0; tick();
    pc = 8'h01; tick();
    tick();
    d_we = 1; d_dataout = 16'h1234; tick();
    d_we = 0;

    ld_start = 1; tick(); ld_start = 0;
    load1(0, 8'h05, 16'h0800);
    ld_valid = 1; ld_sel = 0; ld_addr = 8'h07; ld_data = 16'hABCD; ld_done = 1;
    tick();
    ld_valid = 0; ld_done = 0;
    pc = 8'h07; tick(); tick();
    d_addr = 8'h01; tick();
    pc = 8'h05; tick();
    ld_start = 1; tick(); ld_start = 0;

    for (int k = 0; k < 4; k++) load1(k[0], 8'(16 + k), 16'(16'h1000 + k));
    ld_valid = 1; ld_sel = 0; ld_addr = 8'd20; ld_data = 16'hBEEF;
    #2 reset = 0;
    model_reset();
    push_exp();
    push_exp();
    @(negedge clk);
    ld_valid = 0;
    tick();
    reset = 1; tick();
    ld_done = 1; tick(); ld_done = 0;
    for (int k = 16; k <= 20; k++) begin
      pc = 8'(k); d_addr = 8'(k - 16); tick();
    end
    ld_start = 1; tick(); ld_start = 0;
    ld_done = 1; tick(); ld_done = 0;

    for (int n = 0; n < 400; n++) begin
      pc        = 8'($urandom_range(0, 15));
      d_addr    = 8'($urandom_range(0, 15));
      d_we      = ($urandom_range(0, 3) == 0);
      d_dataout = 16'($urandom);
      ld_valid  = $urandom_range(0, 1) == 1;
      ld_sel    = $urandom_range(0, 1) == 1;
      ld_addr   = 8'($urandom_range(0, 15));
      ld_data   = 16'($urandom);
      ld_done   = ($urandom_range(0, 7) == 0);
      ld_start  = ($urandom_range(0, 15) == 0);
      tick();
    end
    clear_in();
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pcpu_mem.md
PCPU_MEM -- requirements
Module: pcpu_mem

Interface
REQ-001 Parameter AW, 8, address width of both memories (2^AW words each).
REQ-002 Parameter DW, 16, data/instruction word width.
REQ-003 Parameter HALT_OP, 5'b00001, opcode in word bits [DW-1:DW-5] that marks HALT.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 pc  input  AW  CPU instruction fetch address.
REQ-007 i_datain  output  DW  instruction word returned to the CPU.
REQ-008 d_addr  input  AW  CPU data address.
REQ-009 d_we  input  1  CPU data write enable.
REQ-010 d_dataout  input  DW  CPU store data.
REQ-011 d_datain  output  DW  load data returned to the CPU.
REQ-012 cpu_enable  output  1  high only in RUN; drives the CPU enable.
REQ-013 halted  output  1  high in HALTED state.
REQ-014 ld_valid, ld_sel, ld_addr, ld_data  input  1/1/AW/DW  loader write request; ld_sel 0 = instruction memory, 1 = data memory.
REQ-015 ld_ready  output  1  loader may transfer this cycle.
REQ-016 ld_done  input  1  loader end-of-image pulse.
REQ-017 ld_start  input  1  request return to LOAD from RUN or HALTED.
REQ-018 ld_count  output  AW+1  words accepted since last LOAD entry.
REQ-019 cpu_wr_err  output  1  sticky flag: CPU write attempted outside RUN.

Function
REQ-020 FSM states LOAD, RUN, HALTED; the FSM SHALL enter LOAD on reset.
REQ-021 LOAD: ld_ready=1, cpu_enable=0, i_datain and d_datain held at 0 (NOP).
REQ-022 Loader transfer SHALL occur at an edge with ld_valid=1 and ld_ready=1: write ld_data to the ld_sel memory at ld_addr; increment ld_count, saturating at 2^AW.
REQ-023 ld_done=1 in LOAD -> RUN at the next edge; a transfer in the same cycle SHALL still complete; ld_ready SHALL be 0 from that edge.
REQ-024 RUN: i_datain SHALL be registered imem[pc], 1-cycle latency; d_datain SHALL be registered dmem[d_addr], 1-cycle latency.
REQ-025 RUN with d_we=1: dmem[d_addr] <= d_dataout at the edge; a read of the same address in the same cycle SHALL return the new data (write-first).
REQ-026 Instruction memory SHALL be read-only to the CPU; loader requests outside LOAD SHALL be ignored (no write, no count).
REQ-027 RUN: when the word registered onto i_datain has bits [DW-1:DW-5]=HALT_OP -> HALTED at the following edge; cpu_enable drops with that edge.
REQ-028 HALTED: i_datain holds the HALT word; d_datain keeps its last value; d_we ignored.
REQ-029 ld_start=1 in RUN or HALTED -> LOAD at the next edge; ld_count cleared to 0 on entry; halted cleared; ld_start has priority over HALT detection in the same cycle.
REQ-030 ld_start in LOAD SHALL be ignored; ld_done outside LOAD SHALL be ignored.
REQ-031 d_we=1 in LOAD or HALTED SHALL set cpu_wr_err and leave dmem unchanged; cpu_wr_err clears only on reset.
REQ-032 Addresses SHALL wrap modulo 2^AW; no out-of-range condition exists.

Reset
REQ-033 While reset=0: state LOAD, i_datain=0, d_datain=0, cpu_enable=0, halted=0, ld_ready=0, ld_count=0, cpu_wr_err=0, taking effect immediately without a clock.
REQ-034 ld_ready SHALL rise at the first clk edge after reset deasserts.
REQ-035 Memory arrays SHALL NOT be reset; contents are retained across reset, and reset mid-load SHALL discard only the in-flight transfer.

Verification
REQ-036 Load imem[0]=16'h1101, imem[1]=16'h0800, dmem[1]=16'h00C3, pulse ld_done, set pc=0 then 1 -> i_datain 16'h1101 then 16'h0800 one cycle after each pc; ld_count=3.
REQ-037 RUN, d_addr=8'h01 and d_we=0 -> d_datain=16'h00C3 one cycle later; d_we=1 with d_dataout=16'hFC00 -> d_datain=16'hFC00 the next cycle.
REQ-038 imem[5]=16'h0800 (HALT), pc=5 -> i_datain=16'h0800, halted=1 and cpu_enable=0 one edge later; a subsequent d_we=1 sets cpu_wr_err and leaves dmem unchanged.
REQ-039 ld_valid and ld_done high in the same LOAD cycle (ld_addr=8'h07, ld_data=16'hABCD) -> imem[7]=16'hABCD, state RUN, ld_ready=0 after that edge.
REQ-040 Assert reset=0 mid-LOAD after 4 transfers -> outputs reach reset values asynchronously; after release ld_count=0 and previously loaded words read back intact.
REQ-041 ld_start and HALT fetch in the same RUN cycle -> state LOAD, halted stays 0, ld_count=0.
